// File: rtl/alu_op_sequencer.sv
// Issue/sequencing front end for the 32-bit ALU: accepts one op, holds it on the ALU
// for its execution latency, captures the result and returns it over valid/ready.
module alu_op_sequencer #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_op,
   output logic             out_err,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_MAX  = 4'd10;
   localparam logic [3:0] OP_NOP  = 4'd15;
   localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

   state_t     state, state_nxt;
   logic [3:0] op_r;
   logic [3:0] cnt;
   logic       accept;
   logic       op_legal;
   logic       exec_last;

   assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
   assign accept    = in_valid && in_ready;
   assign op_legal  = in_op <= OP_MAX;
   assign exec_last = (state == EXEC) && (cnt == 4'd0);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign alu_op    = (state == EXEC) ? op_r : OP_NOP;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = op_legal ? EXEC : DONE;
         EXEC: if (cnt == 4'd0) state_nxt = DONE;
         DONE: begin
            // a handoff may be overlapped with the next accept
            if (out_ready) begin
               if (!in_valid)     state_nxt = IDLE;
               else if (op_legal) state_nxt = EXEC;
               else               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_r       <= '0;
         cnt        <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         out_result <= '0;
         out_op     <= '0;
         out_err    <= 1'b0;
      end else if (accept) begin
         op_r  <= in_op;
         alu_a <= in_a;
         alu_b <= in_b;
         cnt   <= (in_op == OP_MUL) ? MUL_CNT : 4'd0;
         // rejected opcodes skip EXEC and report straight away
         if (!op_legal) begin
            out_result <= '0;
            out_op     <= in_op;
            out_err    <= 1'b1;
         end
      end else if (exec_last) begin
         out_result <= alu_result;
         out_op     <= op_r;
         out_err    <= 1'b0;
      end else if (state == EXEC) begin
         cnt <= cnt - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                         ops_done <= '0;
      else if (out_valid && out_ready) ops_done <= ops_done + 1'b1;
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, opcode vector table, scoreboard queue,
// and hand-written timing/backpressure/back-to-back/illegal/reset sequences.
module tb_alu_op_sequencer;

   localparam int W = 32;
   localparam int CW = 4;  // narrow counter so the wrap is exercised

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready, out_err, busy;
   logic [3:0]    in_op, alu_op, out_op;
   logic [W-1:0]  in_a, in_b, alu_a, alu_b, alu_result, out_result;
   logic [CW-1:0] ops_done;

   alu_op_sequencer #(.WIDTH(W), .MUL_LAT(4), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_op(out_op), .out_err(out_err), .busy(busy),
      .ops_done(ops_done)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_result = '0;
      case (alu_op)
         4'd0:  alu_result = alu_a + alu_b;
         4'd1:  alu_result = alu_a - alu_b;
         4'd2:  alu_result = alu_a & alu_b;
         4'd3:  alu_result = alu_a | alu_b;
         4'd4:  alu_result = alu_a ^ alu_b;
         4'd5:  alu_result = ~alu_a;
         4'd6:  alu_result = alu_a << alu_b[4:0];
         4'd7:  alu_result = alu_a >> alu_b[4:0];
         4'd8:  alu_result = alu_a * alu_b;
         4'd9:  alu_result = alu_a;
         4'd10: alu_result = alu_b;
         default: alu_result = '0;
      endcase
   end

   typedef struct {logic [3:0] op; logic [W-1:0] res; logic err;} exp_t;
   typedef struct {logic [3:0] op; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] res; logic err;} vec_t;

   exp_t          q[$];
   vec_t          vt[13];
   int            checks = 0;
   int            errors = 0;
   logic [CW-1:0] exp_done = '0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic err, output int waited);
      exp_t e;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'(waited), 32'd0);
         in_valid = 1'b0;
         return;
      end
      e.op = op; e.res = res; e.err = err;
      q.push_back(e);
      tick();
      in_valid = 1'b0;
      in_a = $urandom;
      in_b = $urandom;
      in_op = 4'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_result", out_result, e.res);
            chk("out_op", 32'(out_op), 32'(e.op));
            chk("out_err", 32'(out_err), 32'(e.err));
            chk("ops_done", 32'(ops_done), 32'(exp_done));
            exp_done = exp_done + 1'b1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [CW-1:0] saved;
      int n;

      vt[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0};
      vt[1]  = '{4'd1,  32'h3,         32'h5,         32'hFFFF_FFFE, 1'b0};
      vt[2]  = '{4'd2,  32'hF0F0,      32'hFF00,      32'hF000,      1'b0};
      vt[3]  = '{4'd3,  32'hF0F0,      32'h0F0F,      32'hFFFF,      1'b0};
      vt[4]  = '{4'd4,  32'hAAAA_5555, 32'hFFFF_FFFF, 32'h5555_AAAA, 1'b0};
      vt[5]  = '{4'd5,  32'h1234_5678, 32'h0,         32'hEDCB_A987, 1'b0};
      vt[6]  = '{4'd6,  32'h1,         32'd31,        32'h8000_0000, 1'b0};
      vt[7]  = '{4'd7,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0};
      vt[8]  = '{4'd8,  32'h12345,     32'h10,        32'h123450,    1'b0};
      vt[9]  = '{4'd9,  32'hDEAD,      32'h1,         32'hDEAD,      1'b0};
      vt[10] = '{4'd10, 32'h1,         32'hBEEF,      32'hBEEF,      1'b0};
      vt[11] = '{4'd11, 32'h1,         32'h2,         32'h0,         1'b1};
      vt[12] = '{4'd15, 32'h7,         32'h9,         32'h0,         1'b1};

      rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_alu_op", 32'(alu_op), 32'd15);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ops_done", 32'(ops_done), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // single ADD: one EXEC cycle, result two cycles after accept
      send(4'd0, 32'd5, 32'd7, 32'd12, 1'b0, w);
      @(negedge clk);
      chk("add_exec_op", 32'(alu_op), 32'd0);
      chk("add_exec_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("add_done_op", 32'(alu_op), 32'd15);
      chk("add_done_valid", 32'(out_valid), 32'd1);
      tick();

      // MUL: opcode and operands held four cycles
      send(4'd8, 32'd6, 32'd7, 32'd42, 1'b0, w);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mul_exec_op", 32'(alu_op), 32'd8);
         chk("mul_exec_a", alu_a, 32'd6);
         chk("mul_exec_b", alu_b, 32'd7);
         chk("mul_exec_valid", 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      chk("mul_done_valid", 32'(out_valid), 32'd1);
      chk("mul_done_op", 32'(alu_op), 32'd15);
      tick();

      // backpressure: result held while out_ready is low
      out_ready = 1'b0;
      send(4'd0, 32'd100, 32'd23, 32'd123, 1'b0, w);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid_seen", 32'(out_valid), 32'd1);
      saved = ops_done;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_result", out_result, 32'd123);
         chk("bp_ops_done", 32'(ops_done), 32'(saved));
      end
      tick();
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      chk("bp_ops_done_inc", 32'(ops_done), 32'(saved + 1'b1));
      tick();

      // back-to-back: second op accepted in the handoff cycle
      send(4'd1, 32'd9, 32'd4, 32'd5, 1'b0, w);
      send(4'd4, 32'hF0, 32'h0F, 32'hFF, 1'b0, w);
      chk("b2b_wait", 32'(w), 32'd1);
      @(negedge clk);
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_exec_op", 32'(alu_op), 32'd4);
      drain();

      // illegal opcode: straight to DONE, no EXEC
      send(4'd13, 32'd3, 32'd4, 32'd0, 1'b1, w);
      @(negedge clk);
      chk("ill_valid", 32'(out_valid), 32'd1);
      chk("ill_err", 32'(out_err), 32'd1);
      chk("ill_alu_op", 32'(alu_op), 32'd15);
      drain();

      // opcode table, streamed back to back
      for (int i = 0; i < 13; i++)
         send(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].err, w);
      drain();

      // reset in the middle of a MUL
      send(4'd8, 32'd3, 32'd3, 32'd9, 1'b0, w);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q.delete();
      exp_done = '0;
      @(negedge clk);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_alu_op", 32'(alu_op), 32'd15);
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_ops_done", 32'(ops_done), 32'd0);
      tick();
      send(4'd0, 32'd2, 32'd2, 32'd4, 1'b0, w);
      drain();
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
